// File: rtl/branch_pkg.sv
// branch_pkg: shared encodings for the decode-stage branch controller.
//   - branch op and forward-select encodings
//   - controller FSM state
//   - register, stall-counter and statistics widths
package branch_pkg;

    localparam int REG_W       = 5;
    localparam int STALL_CNT_W = 8;
    localparam int STAT_W      = 32;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_BEQ  = 2'b01,
        OP_BNE  = 2'b10,
        OP_RSVD = 2'b11
    } br_op_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_E  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } br_state_e;

endpackage

// File: rtl/hazard_check.sv
// hazard_check: forwarding/hazard decision for one comparator operand.
//   src          : source register number of the decode instruction
//   e_we/e_ready : E stage writes a register / its value is forwardable now
//   e_dst        : E stage destination
//   m_we/m_ready : same for M stage
//   m_dst        : M stage destination
//   fwd_sel      : 00 register file, 01 E, 10 M
//   hazard       : operand not yet produced (fwd_sel reads 00 in that case)
module hazard_check
    import branch_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             e_we,
    input  logic             e_ready,
    input  logic [REG_W-1:0] e_dst,
    input  logic             m_we,
    input  logic             m_ready,
    input  logic [REG_W-1:0] m_dst,
    output logic [1:0]       fwd_sel,
    output logic             hazard
);

    // E is the younger producer, so it shadows M even when E is not ready.
    always_comb begin
        fwd_sel = FWD_RF;
        hazard  = 1'b0;
        if (src != '0) begin
            if (e_we && (e_dst == src)) begin
                if (e_ready) fwd_sel = FWD_E;
                else         hazard  = 1'b1;
            end else if (m_we && (m_dst == src)) begin
                if (m_ready) fwd_sel = FWD_M;
                else         hazard  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: decode-stage branch controller.
//   Selects forwarded comparator operands, stalls decode while an operand is
//   outstanding, and turns the comparator result into a next-PC select.
//   A watchdog counts consecutive stall cycles and raises sticky stall_err.
// Ports:
//   clk, reset (async, active low)
//   br_valid, br_op, rs, rt          : decode-stage branch
//   e_we/e_ready/e_dst, m_we/m_ready/m_dst : producer info for forwarding
//   flush_d                          : decode flush, overrides everything
//   cmp_eq                           : external comparator equality
//   fwd_sel1/fwd_sel2, stall_d, npc_sel, stall_err
//   br_cnt, taken_cnt, stall_cyc     : only when BRANCH_STATS_EN is defined
// Parameter MAX_STALL (1..255): consecutive stall cycles before stall_err.
// Macro BRANCH_STATS_EN: enables the branch statistics counters.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int MAX_STALL = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    input  logic [1:0]        br_op,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic              e_we,
    input  logic              e_ready,
    input  logic [REG_W-1:0]  e_dst,
    input  logic              m_we,
    input  logic              m_ready,
    input  logic [REG_W-1:0]  m_dst,
    input  logic              flush_d,
    input  logic              cmp_eq,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              stall_d,
    output logic              npc_sel,
    output logic              stall_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] taken_cnt,
    output logic [STAT_W-1:0] stall_cyc
`endif
);

    localparam logic [STALL_CNT_W-1:0] MAX_STALL_C = STALL_CNT_W'(MAX_STALL);

    logic [1:0]             sel1_raw, sel2_raw;
    logic                   haz1, haz2, hazard, active, resolve;
    br_state_e              state, state_nxt;
    logic [STALL_CNT_W-1:0] stall_cnt, stall_cnt_nxt;

    hazard_check u_haz_rs (
        .src     (rs),
        .e_we    (e_we),
        .e_ready (e_ready),
        .e_dst   (e_dst),
        .m_we    (m_we),
        .m_ready (m_ready),
        .m_dst   (m_dst),
        .fwd_sel (sel1_raw),
        .hazard  (haz1)
    );

    hazard_check u_haz_rt (
        .src     (rt),
        .e_we    (e_we),
        .e_ready (e_ready),
        .e_dst   (e_dst),
        .m_we    (m_we),
        .m_ready (m_ready),
        .m_dst   (m_dst),
        .fwd_sel (sel2_raw),
        .hazard  (haz2)
    );

    // Reserved op decodes as "no branch"; flush kills the branch outright.
    assign active = br_valid && ((br_op == OP_BEQ) || (br_op == OP_BNE)) && !flush_d;
    assign hazard = haz1 || haz2;

    // Muxes are forced to the register file while reset is held.
    assign fwd_sel1 = reset ? sel1_raw : FWD_RF;
    assign fwd_sel2 = reset ? sel2_raw : FWD_RF;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (stall_d)  state_nxt = ST_WAIT;
            ST_WAIT: if (!stall_d) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: decisions are combinational so an operand arriving this
    // cycle resolves the branch this cycle.
    always_comb begin
        stall_d = 1'b0;
        npc_sel = 1'b0;
        resolve = 1'b0;
        if (reset && active) begin
            stall_d = hazard;
            resolve = !hazard;
            npc_sel = !hazard && ((br_op == OP_BEQ) ? cmp_eq : !cmp_eq);
        end
    end

    // Watchdog: counts cycles that end in WAIT, clears whenever we leave it.
    always_comb begin
        stall_cnt_nxt = '0;
        if (state_nxt == ST_WAIT)
            stall_cnt_nxt = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_nxt;
            if (stall_cnt_nxt == MAX_STALL_C) stall_err <= 1'b1;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            stall_cyc <= '0;
        end else begin
            if (resolve)            br_cnt    <= br_cnt + 1'b1;
            if (resolve && npc_sel) taken_cnt <= taken_cnt + 1'b1;
            if (stall_d)            stall_cyc <= stall_cyc + 1'b1;
        end
    end
`endif

endmodule
